ucomb_arbiter: RTL and testbench
================================

# ucomb_arbiter

Shares one universal-gate combinational bank (the `ucomb` cluster: `u21`, `u31`, `u41`, `u22` plus the output mux) between two requesters. Each requester submits a 27-bit operand vector over a valid/ready handshake. The arbiter grants one requester at a time, drives the bank from a registered operand, waits a fixed settle cycle, captures the 6-bit result, and returns it over a valid/ready response channel. It sits directly in front of a single `ucomb` instance; the bank is the only resource it schedules.

## Interface

Parameters: none.

Ports:

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has an operand.
- `req0_ready` out 1: requester 0 operand accepted this cycle.
- `req0_data` in 27: requester 0 operand.
- `rsp0_valid` out 1: result available for requester 0.
- `rsp0_ready` in 1: requester 0 consumes the result.
- `rsp0_data` out 6: requester 0 result.
- `req1_valid`, `req1_ready`, `req1_data`, `rsp1_valid`, `rsp1_ready`, `rsp1_data`: same as requester 0, for requester 1.
- `uc_in` out 27: operand driven to the bank.
  - Packing: [3:0] `u21_in`, [9:4] `u31_in`, [19:10] `u41_in`, [25:20] `u22_in`, [26] `u22_sel`.
- `uc_out` in 6: bank result.
  - Packing: [0] `u21_out`, [1] `u31_out`, [2] `u41_out`, [4:3] `u22_out`, [5] `mux_out`.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 1: index of the current or last granted requester.

## Operation

- FSM states: IDLE, DRIVE, CAPTURE, RESP.
- IDLE:
  - If no `reqN_valid` is high, stay in IDLE.
  - Otherwise select a winner. Round-robin: a priority pointer `prio` names the favoured requester; the favoured one wins if it is valid, else the other one wins.
  - `reqW_ready` is a combinational output. It is high only in IDLE, for the winner only, while `reqW_valid` is high.
  - On that edge: latch `reqW_data` into `uc_in`, set `grant` to W, go to DRIVE.
- DRIVE: one settle cycle with `uc_in` stable. Go to CAPTURE.
- CAPTURE: register `uc_out` into the result register. Go to RESP.
- RESP:
  - `rspW_valid` is high and `rspW_data` equals the result register. The other requester's `rsp_valid` is low.
  - Hold state and data until `rspW_ready` is high.
  - On the edge where `rspW_ready` is high: `prio` becomes the other requester (1 − W), go to IDLE.
- `rspN_data` reads the result register for both N. Only the `rsp_valid` qualifies which requester owns it.
- `uc_in` keeps the last operand after a transaction completes. It changes only on an accept edge.
- A request arriving while `busy` is high waits. Its `ready` stays low, and requesters must hold `valid` and `data` stable.
- Both valid in IDLE: `prio` decides the winner. The loser gets no `ready`.

## Timing

- Reset values:
  - State IDLE, `prio`=0, `grant`=0.
  - `uc_in`=0, result register=0.
  - All `ready` and `valid` outputs = 0, `busy`=0.
- Accept edge at cycle T, then DRIVE at T+1, CAPTURE at T+2, RESP with `rsp_valid` high from T+3.
- If `rsp_ready` is already high, the response completes at the T+3 edge and the FSM is in IDLE at T+4.
  - A new accept can occur at T+4 at the earliest.
  - Minimum transaction period: 4 cycles.
- Reset asserted mid-transaction: all state clears immediately and asynchronously to the reset values. The in-flight operation is discarded and no response is produced.
- After reset deassertion, the first accept happens no earlier than the first rising edge with the FSM in IDLE.

## Configuration

- Macro `UCOMB_ARB_FIXED_PRIO_EN`.
  - Defined: requester 0 always wins when both are valid. `prio` is constant 0 and is not updated in RESP.
  - Undefined: round-robin as specified above.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles.
  - Required: all outputs 0.
  - Release and keep both valid low: FSM stays in IDLE, `busy`=0.
- Single request: `req0_valid`=1, `req0_data`=27'h5A3C1F2, bank model computing the reference result, `rsp0_ready`=1.
  - `req0_ready` pulses at T.
  - `rsp0_valid`=1 at T+3 with correct `rsp0_data`.
  - `rsp1_valid` stays 0.
- Contention, round-robin build: both valid continuously, `rsp_ready` high.
  - Grants alternate 0,1,0,1.
  - Each response arrives 4 cycles after the previous one.
- Backpressure: `rsp1_ready`=0 for 5 cycles during RESP.
  - `rsp1_valid` and `rsp1_data` stay stable.
  - `busy`=1 throughout, and no new `req0_ready` is issued.
- Reset mid-op: assert `rst_n`=0 during CAPTURE.
  - All outputs go to 0 immediately.
  - After release, no response is emitted and `uc_in`=0.
- Fixed-priority build with `UCOMB_ARB_FIXED_PRIO_EN` defined: both valid continuously.
  - Requester 0 is granted every transaction; `req1_ready` stays 0.

Source files
------------

// File: rtl/ucomb_arbiter.sv
// Two-requester arbiter in front of a single ucomb gate bank: accept, drive, capture, respond.
// Build option: define UCOMB_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module ucomb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [26:0] req0_data,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [5:0]  rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [26:0] req1_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [5:0]  rsp1_data,
    output logic [26:0] uc_in,
    input  logic [5:0]  uc_out,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

    state_t      state, state_nxt;
    logic        prio;
    logic        grant_q;
    logic        win;
    logic        accept;
    logic        rsp_done;
    logic [26:0] uc_in_p0;
    logic [5:0]  result_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner is the favoured requester if it is valid, otherwise the other one.
    always_comb begin
        state_nxt  = state;
        win        = prio ? req1_valid : ~req0_valid;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~win;
                    req1_ready = win;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                rsp_done   = grant_q ? rsp1_ready : rsp0_ready;
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 1'b0;
        end else if (accept) begin
            grant_q <= win;
        end
    end

`ifdef UCOMB_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (rsp_done) begin
            prio <= ~grant_q;
        end
    end
`endif

    // Stage p0: operand register feeding the bank, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uc_in_p0 <= '0;
        end else if (accept) begin
            uc_in_p0 <= win ? req1_data : req0_data;
        end
    end

    // Stage p1: bank result captured after one full settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
        end else if (state == CAPTURE) begin
            result_p1 <= uc_out;
        end
    end

    assign uc_in     = uc_in_p0;
    assign rsp0_data = result_p1;
    assign rsp1_data = result_p1;
    assign busy      = (state != IDLE);
    assign grant     = grant_q;

endmodule

// File: tb/tb_ucomb_arbiter.sv
// Directed bench for ucomb_arbiter with a behavioural stand-in for the ucomb bank.
module tb_ucomb_arbiter;

`ifdef UCOMB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [26:0] req0_data, req1_data, uc_in;
    logic [5:0]  rsp0_data, rsp1_data, uc_out;
    logic        busy, grant;

    int n_chk  = 0;
    int n_fail = 0;

    ucomb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .uc_in      (uc_in),
        .uc_out     (uc_out),
        .busy       (busy),
        .grant      (grant)
    );

    // Stand-in bank: any fixed function of the packed operand fields will do.
    function automatic logic [5:0] bank(input logic [26:0] x);
        logic [5:0] r;
        r[0]   = ^x[3:0];
        r[1]   = |x[9:4];
        r[2]   = ^x[19:10];
        r[4:3] = x[25:24] ^ x[23:22];
        r[5]   = x[26] ? x[21] : x[20];
        return r;
    endfunction

    assign uc_out = bank(uc_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mp;
        logic        w;
        logic [26:0] op;

        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_data = '0; req1_data = '0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_rdy0", req0_ready, 0);
        check_val("rst_rdy1", req1_ready, 0);
        check_val("rst_rsp0v", rsp0_valid, 0);
        check_val("rst_rsp1v", rsp1_valid, 0);
        check_val("rst_ucin", uc_in, 0);
        check_val("rst_grant", grant, 0);
        check_val("rst_data", rsp0_data, 0);

        rst_n = 1'b1;
        tick(); tick();
        check_val("idle_busy", busy, 0);

        // Single request from requester 0
        req0_valid = 1; req0_data = 27'h5A3C1F2; rsp0_ready = 1;
        #1;
        check_val("single_rdy0", req0_ready, 1);
        check_val("single_rdy1", req1_ready, 0);
        tick();
        req0_valid = 0;
        #1;
        check_val("single_busy", busy, 1);
        check_val("single_ucin", uc_in, 27'h5A3C1F2);
        check_val("single_grant", grant, 0);
        check_val("single_rdy0_drop", req0_ready, 0);
        check_val("single_rsp0v_early", rsp0_valid, 0);
        tick();
        check_val("single_rsp0v_cap", rsp0_valid, 0);
        tick();
        check_val("single_rsp0v", rsp0_valid, 1);
        check_val("single_rsp0d", rsp0_data, bank(27'h5A3C1F2));
        check_val("single_rsp1v", rsp1_valid, 0);
        tick();
        check_val("single_done_busy", busy, 0);
        check_val("single_done_rsp0v", rsp0_valid, 0);
        check_val("single_ucin_hold", uc_in, 27'h5A3C1F2);
        mp = FIXED ? 1'b0 : 1'b1;

        // Backpressure on requester 1; requester 0 arrives while busy
        req1_valid = 1; req1_data = 27'h13579BD; rsp1_ready = 0;
        #1;
        check_val("bp_rdy1", req1_ready, 1);
        check_val("bp_rdy0", req0_ready, 0);
        tick();
        req1_valid = 0; req0_valid = 1; req0_data = 27'h6DB6DB6;
        #1;
        check_val("bp_wait_rdy0", req0_ready, 0);
        check_val("bp_grant", grant, 1);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_rsp1v", rsp1_valid, 1);
            check_val("bp_rsp1d", rsp1_data, bank(27'h13579BD));
            check_val("bp_busy", busy, 1);
            check_val("bp_rdy0", req0_ready, 0);
            check_val("bp_rsp0v", rsp0_valid, 0);
            tick();
        end
        rsp1_ready = 1;
        #1;
        check_val("bp_rsp1v_last", rsp1_valid, 1);
        tick();
        mp = 1'b0;

        // Contention: both valid, responses consumed immediately
        req1_valid = 1; req1_data = 27'h0F0F0F0; rsp0_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            w = mp;
            check_val("ct_rdy0", req0_ready, w == 1'b0);
            check_val("ct_rdy1", req1_ready, w == 1'b1);
            op = w ? req1_data : req0_data;
            tick();
            if (w) req1_data = req1_data + 27'h1234567;
            else   req0_data = req0_data + 27'h2468ACE;
            check_val("ct_grant", grant, w);
            check_val("ct_ucin", uc_in, op);
            tick(); tick();
            check_val("ct_rspv_win", w ? rsp1_valid : rsp0_valid, 1);
            check_val("ct_rspv_lose", w ? rsp0_valid : rsp1_valid, 0);
            check_val("ct_rspd", w ? rsp1_data : rsp0_data, bank(op));
            tick();
            check_val("ct_idle", busy, 0);
            mp = FIXED ? 1'b0 : ~w;
        end
        req0_valid = 0; req1_valid = 0;

        // Reset during CAPTURE
        req1_valid = 1; req1_data = 27'h2AAAAAA;
        #1;
        check_val("mid_rdy1", req1_ready, 1);
        tick();
        req1_valid = 0;
        check_val("mid_grant", grant, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_val("mid_busy", busy, 0);
        check_val("mid_ucin", uc_in, 0);
        check_val("mid_grant_rst", grant, 0);
        check_val("mid_rsp1v", rsp1_valid, 0);
        check_val("mid_rsp1d", rsp1_data, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("post_rsp0v", rsp0_valid, 0);
            check_val("post_rsp1v", rsp1_valid, 0);
            check_val("post_busy", busy, 0);
        end
        check_val("post_ucin", uc_in, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
